rv4028_bus_ram: RTL and testbench

//  Synchronous 16-bit RAM target on the RV4028 external bus, directly downstream of the CPU bus interface.

---
 rtl/rv4028_bus_if.sv | 30 +++
 rtl/rv4028_bus_ram.sv | 102 ++++++++++
 tb/tb_rv4028_bus_ram.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv4028_bus_if.sv
// ============================================================================
// Module  : rv4028_bus_if
// Brief   : RV4028 external bus signal bundle between CPU (master) and RAM target.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface rv4028_bus_if;
    logic [31:0] addr;
    logic        rd_n;
    logic [1:0]  wr_n;
    logic [1:0]  msk_n;
    logic        iorq_n;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        rdata_oe;
    logic        wait_n;

    modport master (
        output addr, rd_n, wr_n, msk_n, iorq_n, bus_wdata,
        input  bus_rdata, rdata_oe, wait_n
    );

    modport slave (
        input  addr, rd_n, wr_n, msk_n, iorq_n, bus_wdata,
        output bus_rdata, rdata_oe, wait_n
    );
endinterface

`default_nettype wire

// File: rtl/rv4028_bus_ram.sv
// ============================================================================
// Module  : rv4028_bus_ram
// Brief   : Synchronous 16-bit RAM target with read wait states and byte masks.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rv4028_bus_ram #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rv4028_bus_if.slave     bus
);

    localparam int          c_DEPTH = 2 ** (ADDR_BITS - 1);
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_STATES);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RD    = 2'd1;
    localparam logic [1:0]  S_WR    = 2'd2;

    logic [15:0]          r_mem [c_DEPTH];
    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-2:0] r_addr;
    logic [1:0]           r_msk_n;
    logic [15:0]          r_ram_q;

    logic                 w_sel;
    logic                 w_wr_req;
    logic                 w_rd_launch;
    logic                 w_rd_done;
    logic [ADDR_BITS-2:0] w_idx;
    logic                 w_unused_addr0;

    assign w_sel          = bus.iorq_n &&
                            (bus.addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign w_wr_req       = ~&bus.wr_n;
    assign w_idx          = bus.addr[ADDR_BITS-1:1];
    assign w_rd_launch    = (r_state == S_IDLE) && w_sel && !bus.rd_n && !w_wr_req;
    assign w_unused_addr0 = bus.addr[0];

    // cnt climbs from 0 and stops at c_WAIT, so "!=" is the same test as "<"
    assign w_rd_done      = (r_state == S_RD) && (r_cnt == c_WAIT);

    assign bus.wait_n     = !((r_state == S_RD) && (r_cnt != c_WAIT));
    assign bus.rdata_oe   = w_rd_done;
    assign bus.bus_rdata  = w_rd_done ? r_ram_q : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_msk_n <= 2'b11;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel && w_wr_req) begin
                        r_addr  <= w_idx;
                        r_msk_n <= bus.msk_n;
                        r_state <= S_WR;
                    end else if (w_rd_launch) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_cnt != c_WAIT) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write commits on the edge closing WR_DATA; an async reset during that
    // cycle has already forced IDLE, so the pending write is dropped.
    always_ff @(posedge clk) begin
        if (r_state == S_WR) begin
            if (!r_msk_n[0]) r_mem[r_addr][7:0]  <= bus.bus_wdata[7:0];
            if (!r_msk_n[1]) r_mem[r_addr][15:8] <= bus.bus_wdata[15:8];
        end
        if (w_rd_launch) begin
            r_ram_q <= r_mem[w_idx];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv4028_bus_ram.sv
// ============================================================================
// Module  : tb_rv4028_bus_ram
// Brief   : Directed self-checking bench for rv4028_bus_ram (1 and 0 wait states).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_rv4028_bus_ram;

    logic        clk;
    logic        rst_n;
    logic        t_dut;
    logic [31:0] t_addr;
    logic        t_rd_n;
    logic [1:0]  t_wr_n;
    logic [1:0]  t_msk_n;
    logic        t_iorq_n;
    logic [15:0] t_wdata;

    int          errors;
    int          checks;

    rv4028_bus_if bus1 ();
    rv4028_bus_if bus0 ();

    rv4028_bus_ram #(.ADDR_BITS(12), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    rv4028_bus_ram #(.ADDR_BITS(12), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_w0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    assign bus1.addr      = t_addr;
    assign bus1.msk_n     = t_msk_n;
    assign bus1.iorq_n    = t_iorq_n;
    assign bus1.bus_wdata = t_wdata;
    assign bus1.rd_n      = t_dut ? t_rd_n : 1'b1;
    assign bus1.wr_n      = t_dut ? t_wr_n : 2'b11;
    assign bus0.addr      = t_addr;
    assign bus0.msk_n     = t_msk_n;
    assign bus0.iorq_n    = t_iorq_n;
    assign bus0.bus_wdata = t_wdata;
    assign bus0.rd_n      = t_dut ? 1'b1 : t_rd_n;
    assign bus0.wr_n      = t_dut ? 2'b11 : t_wr_n;

    logic        o_wait_n;
    logic        o_oe;
    logic [15:0] o_rdata;
    assign o_wait_n = t_dut ? bus1.wait_n    : bus0.wait_n;
    assign o_oe     = t_dut ? bus1.rdata_oe  : bus0.rdata_oe;
    assign o_rdata  = t_dut ? bus1.bus_rdata : bus0.bus_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        t_rd_n   = 1'b1;
        t_wr_n   = 2'b11;
        t_msk_n  = 2'b11;
        t_iorq_n = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] d,
                            input logic [1:0] m, input logic iorq);
        @(negedge clk);
        t_addr = a; t_wr_n = 2'b00; t_msk_n = m; t_wdata = d; t_iorq_n = iorq;
        @(negedge clk);
        checks++;
        if (o_wait_n !== 1'b1) begin
            errors++;
            $display("FAIL wr_wait_n @%h: got %b expected 1", a, o_wait_n);
        end
        t_wr_n = 2'b11;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [15:0] d,
                           output logic oe, output int waits);
        @(negedge clk);
        t_addr = a; t_rd_n = 1'b0; t_iorq_n = 1'b1;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_wait_n === 1'b0) waits++;
            else break;
        end
        if (o_wait_n !== 1'b1) waits = -1;
        d  = o_rdata;
        oe = o_oe;
        t_rd_n = 1'b1;
    endtask

    task automatic test_reset();
        t_dut = 1'b1;
        rst_n = 1'b0;
        t_addr = 32'h10; t_rd_n = 1'b0; t_wr_n = 2'b00; t_msk_n = 2'b00;
        t_iorq_n = 1'b1; t_wdata = 16'hA5A5;
        #3;
        checks += 3;
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_n: got %b expected 1", o_wait_n); end
        if (o_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", o_oe); end
        if (o_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0000", o_rdata); end
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        // Async reset in the middle of a read data phase
        @(negedge clk);
        t_addr = 32'h40; t_rd_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_oe !== 1'b1) begin errors++; $display("FAIL pre_rst_oe: got %b expected 1", o_oe); end
        #1 rst_n = 1'b0;
        #1;
        checks += 3;
        if (o_oe !== 1'b0) begin errors++; $display("FAIL async_rst_oe: got %b expected 0", o_oe); end
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL async_rst_wait_n: got %b expected 1", o_wait_n); end
        if (o_rdata !== 16'h0) begin errors++; $display("FAIL async_rst_rdata: got %h expected 0000", o_rdata); end
        #1 rst_n = 1'b1;
        t_rd_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [15:0] d; logic oe; int w;
        t_dut = 1'b1;
        do_write(32'h010, 16'hBEEF, 2'b00, 1'b1);
        do_read(32'h010, d, oe, w);
        checks += 3;
        if (w != 1) begin errors++; $display("FAIL wr_rd_waits: got %0d expected 1", w); end
        if (oe !== 1'b1) begin errors++; $display("FAIL wr_rd_oe: got %b expected 1", oe); end
        if (d !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_data: got %h expected beef", d); end
    endtask

    task automatic test_byte_mask();
        logic [15:0] d; logic oe; int w;
        t_dut = 1'b1;
        do_write(32'h010, 16'h12AB, 2'b10, 1'b1);
        do_read(32'h010, d, oe, w);
        checks++;
        if (d !== 16'hBEAB) begin errors++; $display("FAIL byte_lo: got %h expected beab", d); end
        do_write(32'h010, 16'h5555, 2'b11, 1'b1);
        do_read(32'h010, d, oe, w);
        checks++;
        if (d !== 16'hBEAB) begin errors++; $display("FAIL mask_none: got %h expected beab", d); end
        do_write(32'h010, 16'h7700, 2'b01, 1'b1);
        do_read(32'h010, d, oe, w);
        checks++;
        if (d !== 16'h77AB) begin errors++; $display("FAIL byte_hi: got %h expected 77ab", d); end
        do_write(32'h010, 16'hBEAB, 2'b00, 1'b1);
    endtask

    task automatic test_unselected();
        logic [15:0] d; logic oe; int w;
        t_dut = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            t_addr   = (k == 0) ? 32'h0000_0010 : 32'h0800_0010;
            t_iorq_n = (k == 0) ? 1'b0 : 1'b1;
            t_rd_n   = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks += 2;
                if (o_wait_n !== 1'b1) begin errors++; $display("FAIL unsel_wait_n k=%0d c=%0d: got %b expected 1", k, c, o_wait_n); end
                if (o_oe !== 1'b0) begin errors++; $display("FAIL unsel_oe k=%0d c=%0d: got %b expected 0", k, c, o_oe); end
            end
            idle_bus();
        end
        do_write(32'h0000_0010, 16'h0000, 2'b00, 1'b0);
        do_write(32'h0800_0010, 16'h1111, 2'b00, 1'b1);
        idle_bus();
        do_read(32'h010, d, oe, w);
        checks++;
        if (d !== 16'hBEAB) begin errors++; $display("FAIL unsel_ram: got %h expected beab", d); end
    endtask

    task automatic test_back_to_back();
        t_dut = 1'b0;
        do_write(32'h020, 16'h5678, 2'b00, 1'b1);
        do_write(32'h022, 16'h1234, 2'b00, 1'b1);
        @(negedge clk);
        t_addr = 32'h020; t_rd_n = 1'b0;
        checks++;
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL b2b_c0_wait_n: got %b expected 1", o_wait_n); end
        @(negedge clk);
        checks += 3;
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL b2b_c1_wait_n: got %b expected 1", o_wait_n); end
        if (o_oe !== 1'b1) begin errors++; $display("FAIL b2b_c1_oe: got %b expected 1", o_oe); end
        if (o_rdata !== 16'h5678) begin errors++; $display("FAIL b2b_lo: got %h expected 5678", o_rdata); end
        t_addr = 32'h022;
        @(negedge clk);
        checks += 2;
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL b2b_c2_wait_n: got %b expected 1", o_wait_n); end
        if (o_oe !== 1'b0) begin errors++; $display("FAIL b2b_c2_oe: got %b expected 0", o_oe); end
        @(negedge clk);
        checks += 3;
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL b2b_c3_wait_n: got %b expected 1", o_wait_n); end
        if (o_oe !== 1'b1) begin errors++; $display("FAIL b2b_c3_oe: got %b expected 1", o_oe); end
        if (o_rdata !== 16'h1234) begin errors++; $display("FAIL b2b_hi: got %h expected 1234", o_rdata); end
        t_rd_n = 1'b1;
    endtask

    task automatic test_reset_write();
        logic [15:0] d; logic oe; int w;
        t_dut = 1'b1;
        do_write(32'h030, 16'h0000, 2'b00, 1'b1);
        @(negedge clk);
        t_addr = 32'h030; t_wr_n = 2'b00; t_msk_n = 2'b00; t_wdata = 16'hFFFF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (o_wait_n !== 1'b1) begin errors++; $display("FAIL rstwr_wait_n: got %b expected 1", o_wait_n); end
        if (o_oe !== 1'b0) begin errors++; $display("FAIL rstwr_oe: got %b expected 0", o_oe); end
        @(negedge clk);
        t_wr_n = 2'b11;
        rst_n  = 1'b1;
        do_read(32'h030, d, oe, w);
        checks += 2;
        if (w != 1) begin errors++; $display("FAIL rstwr_waits: got %0d expected 1", w); end
        if (d !== 16'h0000) begin errors++; $display("FAIL rstwr_data: got %h expected 0000", d); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_unselected();
        test_back_to_back();
        test_reset_write();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
